cmp_share_arbiter: RTL and testbench
====================================

Name: cmp_share_arbiter

Overview:
- Shares one 4-bit equal/not-equal compare unit between NREQ requesters using round-robin arbitration.
- Each requester presents operands A, B and a mode bit sel over a valid/ready handshake.
- sel=1 asks "A==B"; sel=0 asks "A!=B".
- The block grants one request at a time, runs the comparison, and returns the 1-bit result tagged with the requester id on a valid/ready response channel. It sits between the requester agents and the comparator datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, operand width in bits.
- IDW, 2, id width, equal to clog2(NREQ).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*W  flattened A operands; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  flattened B operands, same packing as req_a.
- req_sel  in  NREQ  per-requester mode: 1 = equality, 0 = inequality.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_y  out  1  comparison result.
- busy  out  1  high whenever the FSM is not in IDLE.
- done_cnt  out  8  count of completed responses; wraps from 255 to 0.

Behaviour:
- Reset: clk and rst_n are fixed as one clock with synchronous, active-low reset. When rst_n=0 at a rising edge:
  - state goes to IDLE and ptr to 0.
  - rsp_valid=0, rsp_y=0, rsp_id=0, busy=0, done_cnt=0.
  - req_ready is all zeros during the reset cycle.
- Reset mid-transaction aborts it. No response is ever produced for the aborted request, and its requester must re-request.

FSM: IDLE -> CMP -> RESP -> IDLE.

IDLE:
- Grant g is the first index i with req_valid[i]=1, scanning ptr, ptr+1, ..., wrapping mod NREQ.
- req_ready is combinational and one-hot at g. It is all zeros if no request is valid.
- On handshake (req_valid[g] & req_ready[g]):
  - Latch A, B, sel and g.
  - Set ptr <= (g+1) mod NREQ.
  - Go to CMP.
- No valid request: stay in IDLE; ptr unchanged.

CMP (exactly 1 cycle):
- req_ready is all zeros.
- Computes y = sel ? (A==B) : (A!=B) on the latched operands (bitwise XNOR-AND for equality, XOR-OR for inequality).
- Registers y into rsp_y and g into rsp_id, sets rsp_valid=1, and goes to RESP.

RESP:
- rsp_valid=1, with rsp_y and rsp_id held stable.
- req_ready is all zeros, so new requests stall.
- On rsp_ready=1:
  - rsp_valid <= 0 and done_cnt <= done_cnt+1.
  - Go to IDLE.
- rsp_ready low holds RESP indefinitely.

Latency and throughput:
- A request handshake at cycle t gives rsp_valid=1 in cycle t+2.
- Minimum spacing between grants is 3 cycles.
- One transaction is outstanding at most.

Fairness:
- A requester that was just served has the lowest priority at the next arbitration.
- Simultaneous valids resolve by ptr order.
- A requester dropping req_valid before being granted is legal and causes no state change.

Other rules:
- Operand and sel changes after the handshake have no effect on the in-flight result.
- busy = (state != IDLE).
- done_cnt wraps from 255 to 0 without saturation.

Test Plan:
- Reset then a single request: req_valid=0001, A0=1010, B0=1010, sel0=1, rsp_ready=1.
  - Expect req_ready=0001 in the handshake cycle.
  - Expect rsp_valid 2 cycles later with rsp_y=1, rsp_id=0, then done_cnt=1.
- Inequality path: requester 2 sends A=1100, B=1001, sel=0 -> rsp_y=1, rsp_id=2. Repeat with A=B=1111, sel=0 -> rsp_y=0.
- Round-robin: req_valid=1111 held continuously, rsp_ready=1.
  - Expect rsp_id sequence 0,1,2,3,0 with grants 3 cycles apart.
  - Requester 0 re-requesting immediately must not be granted before requesters 1..3.
- Backpressure: rsp_ready=0 for 5 cycles in RESP.
  - Expect rsp_valid, rsp_y and rsp_id stable and req_ready=0000 throughout.
  - Raise rsp_ready: the response completes and the next grant occurs 1 cycle later.
- Reset mid-operation: assert rst_n=0 during CMP or RESP.
  - Next cycle: rsp_valid=0, busy=0, done_cnt=0, ptr=0.
  - A subsequent req_valid=1010 grants requester 1.
- Counter wrap: run 256 completed transactions -> done_cnt returns to 0. Operands changed after the handshake (A 0000 -> 1111) do not alter rsp_y.

Source files
------------

// File: rtl/cmp_share_arbiter_if.sv
// Request/response bundle for the shared compare unit.
// Requesters drive through master; the arbiter uses slave.
interface cmp_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sel;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_y;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one equal/not-equal compare unit.
// One transaction in flight: IDLE grant, CMP compute, RESP hold.
module cmp_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  cmp_share_arbiter_if.slave  bus,
  output logic                busy,
  output logic [7:0]          done_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt;
  logic           found;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           sel_q;
  logic [IDW-1:0] g_q;
  logic [W-1:0]   diff;
  int             idx;

  // First valid requester scanning from ptr upward, wrapping.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  // Ready is one-hot at the grant, only while idle and out of reset.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && state == IDLE && found)
      bus.req_ready[gnt] = 1'b1;
  end

  assign busy = (state != IDLE);
  assign diff = a_q ^ b_q;

  // Transaction FSM, operand latch, response and completion counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      a_q           <= '0;
      b_q           <= '0;
      sel_q         <= 1'b0;
      g_q           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_y     <= 1'b0;
      bus.rsp_id    <= '0;
      done_cnt      <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (found) begin
            a_q   <= bus.req_a[int'(gnt)*W +: W];
            b_q   <= bus.req_b[int'(gnt)*W +: W];
            sel_q <= bus.req_sel[gnt];
            g_q   <= gnt;
            ptr   <= IDW'((int'(gnt) + 1) % NREQ);
            state <= CMP;
          end
        end
        (state == CMP): begin
          bus.rsp_y     <= sel_q ? &(~diff) : |diff;
          bus.rsp_id    <= g_q;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        (state == RESP): begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            done_cnt      <= done_cnt + 8'd1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter.
// Directed scenarios followed by a long randomized run.
module tb_cmp_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] done_cnt;

  cmp_share_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  cmp_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  typedef struct {
    int id;
    bit y;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   ptr_m   = 0;
  int   cnt_m   = 0;
  bit   busy_m  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  // Monitor: mid-cycle sampling against the rule-level model.
  always @(negedge clk) begin
    int g;
    int a;
    int b;
    int exp_rdy;
    bit exp_v;
    cyc++;
    if (!rst_n) begin
      chk("ready_in_reset", int'(bus.req_ready), 0);
      q.delete();
      busy_m = 0;
      ptr_m  = 0;
      cnt_m  = 0;
    end else begin
      g = -1;
      if (!busy_m)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && bus.req_valid[(ptr_m + k) % NREQ])
            g = (ptr_m + k) % NREQ;
      exp_rdy = (g >= 0) ? (1 << g) : 0;
      chk("req_ready", int'(bus.req_ready), exp_rdy);
      chk("busy", int'(busy), int'(busy_m));
      chk("done_cnt", int'(done_cnt), cnt_m);
      if (q.size() > 0) begin
        exp_v = (cyc >= q[0].due);
        chk("rsp_valid", int'(bus.rsp_valid), int'(exp_v));
        if (bus.rsp_valid && exp_v) begin
          chk("rsp_id", int'(bus.rsp_id), q[0].id);
          chk("rsp_y", int'(bus.rsp_y), int'(q[0].y));
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            cnt_m  = (cnt_m + 1) % 256;
            busy_m = 0;
          end
        end
      end else begin
        chk("rsp_valid_idle", int'(bus.rsp_valid), 0);
      end
      if (g >= 0) begin
        a = int'(bus.req_a[g*W +: W]);
        b = int'(bus.req_b[g*W +: W]);
        q.push_back('{id: g,
                      y: bus.req_sel[g] ? (a == b) : (a != b),
                      due: cyc + 2});
        busy_m = 1;
        ptr_m  = (g + 1) % NREQ;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_sel[i]      = s;
  endtask

  initial begin
    logic [W-1:0] ra;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single equality request on requester 0.
    set_req(0, 4'b1010, 4'b1010, 1'b1);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    repeat (5) tick();

    // Inequality path on requester 2, true then false.
    set_req(2, 4'b1100, 4'b1001, 1'b0);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    repeat (4) tick();
    set_req(2, 4'b1111, 4'b1111, 1'b0);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    repeat (4) tick();

    // Round robin with all requesters pending.
    for (int i = 0; i < NREQ; i++)
      set_req(i, W'(i), W'(3 - i), i[0]);
    bus.req_valid = 4'b1111;
    repeat (16) tick();
    bus.req_valid = '0;
    repeat (4) tick();

    // Backpressure in RESP, then a grant right after completion.
    bus.rsp_ready = 1'b0;
    set_req(3, 4'b0110, 4'b0110, 1'b1);
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    repeat (7) tick();
    bus.req_valid = 4'b0010;
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = '0;
    repeat (5) tick();

    // Reset while the transaction sits in CMP.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1010;
    tick();
    bus.req_valid = '0;
    repeat (4) tick();

    // Random traffic; operands churn every cycle and the
    // completion count runs well past one wrap.
    repeat (1600) begin
      bus.req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        ra = W'($urandom);
        set_req(i, ra, ($urandom % 2) ? ra : W'($urandom),
                1'($urandom));
      end
      bus.rsp_ready = ($urandom % 4) != 0;
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (6) tick();

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
